// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: issues reads only when a skid slot is
// reserved, captures returning words, and presents them as a valid/ready stream.
module fifo_rd_stream #(
  parameter int DATA_WIDTH     = 65,
  parameter int BUF_ADDR_WIDTH = 2
) (
  input  logic                    Clk,
  input  logic                    Clear_in,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    fifo_data_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BUF_ADDR_WIDTH:0] buf_count,
  output logic                    err_overflow,
  output logic                    err_unexpected,
  output logic [31:0]             deliver_count
);

  localparam int DEPTH = 1 << BUF_ADDR_WIDTH;
  localparam logic [BUF_ADDR_WIDTH:0] DEPTH_CNT = (BUF_ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0]   skid_mem [DEPTH];
  logic [BUF_ADDR_WIDTH-1:0] wr_ptr;
  logic [BUF_ADDR_WIDTH-1:0] rd_ptr;
  logic [BUF_ADDR_WIDTH:0]   count_q;
  logic                      inflight;
  logic                      overflow_q;
  logic                      unexpected_q;
  logic [31:0]               deliver_q;

  logic                      pop;
  logic                      has_space;
  logic                      push;
  logic [BUF_ADDR_WIDTH+1:0] occupancy;

  // A read is only issued if the word it returns already has a free slot,
  // counting the word still in flight from the previous cycle.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{(BUF_ADDR_WIDTH+1){1'b0}}, inflight};
    fifo_rd_en = !Clear_in && !fifo_empty && (occupancy < {1'b0, DEPTH_CNT});
    out_valid  = (count_q != '0);
    pop        = out_valid && out_ready;
    has_space  = (count_q < DEPTH_CNT) || pop;
    push       = fifo_data_valid && has_space;
    out_data   = skid_mem[rd_ptr];
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      inflight     <= 1'b0;
      overflow_q   <= 1'b0;
      unexpected_q <= 1'b0;
      deliver_q    <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (fifo_data_valid && !has_space)
        overflow_q <= 1'b1;
      if (fifo_data_valid && !inflight)
        unexpected_q <= 1'b1;
      if (pop && (deliver_q != 32'hFFFF_FFFF))
        deliver_q <= deliver_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !Clear_in)
      skid_mem[wr_ptr] <= fifo_data;
  end

  assign buf_count      = count_q;
  assign err_overflow   = overflow_q;
  assign err_unexpected = unexpected_q;
  assign deliver_count  = deliver_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a one-cycle-latency FIFO model feeds the
// adapter and a monitor checks delivered words against the load order.
module tb_fifo_rd_stream;

  localparam int DW = 65;

  logic          clk = 1'b0;
  logic          Clear_in;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          fifo_data_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    buf_count;
  logic          err_overflow;
  logic          err_unexpected;
  logic [31:0]   deliver_count;

  logic [DW-1:0] mem   [0:4095];
  logic [DW-1:0] exp_q [0:4095];
  int head = 0;
  int tail = 0;
  int exp_wr = 0;
  int exp_rd = 0;
  int total = 0;
  int bad = 0;

  logic          model_valid = 1'b0;
  logic [DW-1:0] model_data = '0;
  logic          inj_valid;
  logic [DW-1:0] inj_data;

  always #5 clk = ~clk;

  assign fifo_empty      = (head == tail);
  assign fifo_data_valid = model_valid | inj_valid;
  assign fifo_data       = inj_valid ? inj_data : model_data;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_ADDR_WIDTH(2)) dut (
    .Clk            (clk),
    .Clear_in       (Clear_in),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data      (fifo_data),
    .fifo_data_valid(fifo_data_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .buf_count      (buf_count),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected),
    .deliver_count  (deliver_count)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  // FIFO model shares Clear_in, so a clear also flushes its contents
  always @(posedge clk) begin
    if (Clear_in) begin
      model_valid <= 1'b0;
      head        <= tail;
    end else if (fifo_rd_en && (head != tail)) begin
      model_data  <= mem[head];
      model_valid <= 1'b1;
      head        <= head + 1;
    end else begin
      model_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (Clear_in) begin
      exp_rd = exp_wr;
    end else begin
      checkOutput("bufmax", {64'd0, buf_count <= 3'd4}, 65'd1);
      if (out_valid && out_ready) begin
        if (exp_rd == exp_wr) begin
          checkOutput("extra_beat", out_data, 65'd0);
        end else begin
          checkOutput("data_order", out_data, exp_q[exp_rd]);
          exp_rd++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] word);
    mem[tail]     = word;
    exp_q[exp_wr] = word;
    tail++;
    exp_wr++;
  endtask

  function automatic bit drained();
    return (exp_rd == exp_wr) && (head == tail) && (buf_count == 3'd0) && !fifo_data_valid;
  endfunction

  task automatic waitDrained(input int budget);
    int n = 0;
    while (!drained() && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("drain_timeout", {64'd0, n < budget}, 65'd1);
  endtask

  initial begin
    int h0;
    Clear_in  = 1'b1;
    out_ready = 1'b0;
    inj_valid = 1'b0;
    inj_data  = '0;
    tick(3);
    Clear_in = 1'b0;

    // idle with empty FIFO
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("idle_rd_en", {64'd0, fifo_rd_en}, 65'd0);
      checkOutput("idle_valid", {64'd0, out_valid}, 65'd0);
      checkOutput("idle_count", {62'd0, buf_count}, 65'd0);
      checkOutput("idle_flags", {63'd0, err_overflow, err_unexpected}, 65'd0);
    end

    // three words, consumer always ready: latency and back-to-back delivery
    out_ready = 1'b1;
    applyStimulus(65'h1);
    applyStimulus(65'h2);
    applyStimulus(65'h3);
    #1;
    checkOutput("lat_rd_c1", {64'd0, fifo_rd_en}, 65'd1);
    tick(1);
    checkOutput("lat_rd_c2", {64'd0, fifo_rd_en}, 65'd1);
    checkOutput("lat_valid_c2", {64'd0, out_valid}, 65'd0);
    tick(1);
    checkOutput("lat_rd_c3", {64'd0, fifo_rd_en}, 65'd1);
    checkOutput("lat_valid_c3", {64'd0, out_valid}, 65'd1);
    checkOutput("lat_data_c3", out_data, 65'h1);
    tick(1);
    checkOutput("lat_rd_c4", {64'd0, fifo_rd_en}, 65'd0);
    checkOutput("lat_data_c4", out_data, 65'h2);
    tick(1);
    checkOutput("lat_data_c5", out_data, 65'h3);
    tick(1);
    checkOutput("lat_valid_c6", {64'd0, out_valid}, 65'd0);
    checkOutput("lat_deliver", {33'd0, deliver_count}, 65'd3);

    // backpressure: ten words, consumer stalled
    out_ready = 1'b0;
    h0 = head;
    for (int i = 0; i < 10; i++)
      applyStimulus(65'h100 + 65'(i));
    tick(10);
    checkOutput("bp_reads", 65'(head - h0), 65'd4);
    checkOutput("bp_count", {62'd0, buf_count}, 65'd4);
    checkOutput("bp_rd_en", {64'd0, fifo_rd_en}, 65'd0);
    checkOutput("bp_data0", out_data, 65'h100);
    tick(3);
    checkOutput("bp_stable", out_data, 65'h100);
    out_ready = 1'b1;
    waitDrained(200);
    checkOutput("bp_overflow", {64'd0, err_overflow}, 65'd0);
    checkOutput("bp_deliver", {33'd0, deliver_count}, 65'd13);

    // random backpressure over many pointer wraps
    for (int i = 0; i < 1000; i++)
      applyStimulus({1'b1, 32'($urandom), 32'($urandom)});
    for (int c = 0; c < 20000 && !drained(); c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    out_ready = 1'b1;
    waitDrained(200);
    checkOutput("rnd_deliver", {33'd0, deliver_count}, 65'd1013);
    checkOutput("rnd_flags", {63'd0, err_overflow, err_unexpected}, 65'd0);

    // unexpected arrival with no read in flight
    out_ready = 1'b0;
    inj_data  = 65'hAA;
    inj_valid = 1'b1;
    exp_q[exp_wr] = 65'hAA;
    exp_wr++;
    tick(1);
    inj_valid = 1'b0;
    checkOutput("unexp_flag", {64'd0, err_unexpected}, 65'd1);
    checkOutput("unexp_count", {62'd0, buf_count}, 65'd1);
    checkOutput("unexp_no_ovf", {64'd0, err_overflow}, 65'd0);

    // fill the buffer, then force an arrival that must be dropped
    applyStimulus(65'hB1);
    applyStimulus(65'hB2);
    applyStimulus(65'hB3);
    tick(8);
    checkOutput("full_count", {62'd0, buf_count}, 65'd4);
    inj_data  = 65'hDEAD;
    inj_valid = 1'b1;
    tick(1);
    inj_valid = 1'b0;
    checkOutput("ovf_flag", {64'd0, err_overflow}, 65'd1);
    checkOutput("ovf_count", {62'd0, buf_count}, 65'd4);
    checkOutput("ovf_head", out_data, 65'hAA);
    tick(2);
    checkOutput("sticky_flags", {63'd0, err_overflow, err_unexpected}, 65'd3);
    out_ready = 1'b1;
    waitDrained(100);
    checkOutput("ovf_deliver", {33'd0, deliver_count}, 65'd1017);
    checkOutput("sticky_after", {63'd0, err_overflow, err_unexpected}, 65'd3);

    // clear mid-transfer with three buffered words and one in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(65'h200 + 65'(i));
    #1;
    tick(4);
    checkOutput("pre_clr_count", {62'd0, buf_count}, 65'd3);
    checkOutput("pre_clr_flight", {64'd0, fifo_data_valid}, 65'd1);
    Clear_in = 1'b1;
    #1;
    checkOutput("clr_rd_en", {64'd0, fifo_rd_en}, 65'd0);
    tick(1);
    checkOutput("clr_count", {62'd0, buf_count}, 65'd0);
    checkOutput("clr_valid", {64'd0, out_valid}, 65'd0);
    checkOutput("clr_deliver", {33'd0, deliver_count}, 65'd0);
    checkOutput("clr_flags", {63'd0, err_overflow, err_unexpected}, 65'd0);
    Clear_in = 1'b0;
    tick(1);
    out_ready = 1'b1;
    applyStimulus(65'h301);
    applyStimulus(65'h302);
    waitDrained(100);
    checkOutput("post_deliver", {33'd0, deliver_count}, 65'd2);
    checkOutput("post_flags", {63'd0, err_overflow, err_unexpected}, 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
